// File: rtl/cruise_pkg.sv
// Shared definitions for the cruise scheduler: state encoding, datapath step and op encoding.
package cruise_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_ARMED  = 2'd1,
        ST_CRUISE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam logic [7:0] STEP   = 8'd5;
    localparam logic       OP_ADD = 1'b0;
    localparam logic       OP_SUB = 1'b1;

    // Magnitude of the gap between two speeds.
    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/add_sub.sv
// Shared 8-bit add/subtract-by-STEP unit; saturates when CRUISE_SCHED_SAT_EN is defined,
// otherwise wraps modulo 256.
module add_sub
    import cruise_pkg::*;
(
    input  logic [7:0] a,
    input  logic       sub,
    output logic [7:0] result,
    output logic       carry
);

    logic [7:0] operand_b;
    logic [8:0] sum;

    // Subtraction as a + ~STEP + 1, so carry-out high means no borrow.
    always_comb begin
        operand_b = (sub == OP_SUB) ? ~STEP : STEP;
        sum       = {1'b0, a} + {1'b0, operand_b} + {8'd0, sub};
        carry     = sum[8];
    end

`ifdef CRUISE_SCHED_SAT_EN
    always_comb begin
        if ((sub == OP_ADD) && carry) begin
            result = 8'd255;
        end else if ((sub == OP_SUB) && !carry) begin
            result = 8'd0;
        end else begin
            result = sum[7:0];
        end
    end
`else
    always_comb begin
        result = sum[7:0];
    end
`endif

endmodule

// File: rtl/cruise_sched.sv
// Cruise-control scheduler: prioritised request decode, one shared +/-5 datapath,
// target regulation. Saturating arithmetic is selected with CRUISE_SCHED_SAT_EN.
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_OFF    | cruise disarmed, driver adjusts speed directly
// ST_ARMED  | cruise armed, waiting for a valid set
// ST_CRUISE | regulating speed toward cruise_speed
// ST_HOLD   | braked out of cruise, target retained for resume
module cruise_sched
    import cruise_pkg::*;
#(
    parameter logic [7:0] MIN_CRUISE = 8'd45
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       on,
    input  logic       off,
    input  logic       set,
    input  logic       brake,
    input  logic       accel,
    input  logic       decel,
    output logic [7:0] speed,
    output logic [7:0] cruise_speed,
    output logic [1:0] state,
    output logic       op_valid,
    output logic       op_sub
);

    state_t     state_q, state_n;
    logic [7:0] speed_q, speed_n;
    logic [7:0] cruise_q, cruise_n;
    logic       op_valid_q, op_sub_q;

    logic req_brake, req_on, req_set, req_accel, req_decel, req_none;

    logic       op_en;
    logic       op_sub_c;
    logic       op_cruise;
    logic       floor_en;
    logic       cap;
    logic       clr;
    logic       snap;
    logic [7:0] op_a;
    logic [7:0] op_result;
    logic       op_carry;
    logic [7:0] gap;
    logic       set_ok;

    // Only the highest-priority request survives; off is handled separately above all.
    always_comb begin
        req_brake = brake;
        req_on    = on    & ~brake;
        req_set   = set   & ~brake & ~on;
        req_accel = accel & ~brake & ~on & ~set;
        req_decel = decel & ~brake & ~on & ~set & ~accel;
        req_none  = ~(brake | on | set | accel | decel);
    end

    always_comb begin
        gap    = abs_diff(speed_q, cruise_q);
        set_ok = (speed_q >= MIN_CRUISE);
    end

    always_comb begin
        state_n   = state_q;
        op_en     = 1'b0;
        op_sub_c  = OP_ADD;
        op_cruise = 1'b0;
        floor_en  = 1'b0;
        cap       = 1'b0;
        clr       = 1'b0;
        snap      = 1'b0;
        if (off) begin
            state_n = ST_OFF;
            clr     = 1'b1;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    clr = 1'b1;
                    if (req_brake || req_decel) begin
                        op_en    = 1'b1;
                        op_sub_c = OP_SUB;
                    end else if (req_on) begin
                        state_n = ST_ARMED;
                    end else if (req_accel) begin
                        op_en = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (req_brake || req_decel) begin
                        op_en    = 1'b1;
                        op_sub_c = OP_SUB;
                    end else if (req_set && set_ok) begin
                        cap     = 1'b1;
                        state_n = ST_CRUISE;
                    end else if (req_accel) begin
                        op_en = 1'b1;
                    end
                end
                ST_CRUISE: begin
                    if (req_brake) begin
                        op_en    = 1'b1;
                        op_sub_c = OP_SUB;
                        state_n  = ST_HOLD;
                    end else if (req_set && set_ok) begin
                        cap = 1'b1;
                    end else if (req_accel) begin
                        op_en     = 1'b1;
                        op_cruise = 1'b1;
                    end else if (req_decel) begin
                        op_en     = 1'b1;
                        op_cruise = 1'b1;
                        op_sub_c  = OP_SUB;
                        floor_en  = 1'b1;
                    end else if (req_none && (gap != 8'd0)) begin
                        // Close gaps smaller than one step directly, without the datapath.
                        if (gap < STEP) begin
                            snap = 1'b1;
                        end else begin
                            op_en    = 1'b1;
                            op_sub_c = (speed_q > cruise_q) ? OP_SUB : OP_ADD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (req_brake || req_decel) begin
                        op_en    = 1'b1;
                        op_sub_c = OP_SUB;
                    end else if (req_set && set_ok) begin
                        cap     = 1'b1;
                        state_n = ST_CRUISE;
                    end else if (req_accel) begin
                        state_n = ST_CRUISE;
                    end
                end
                default: state_n = ST_OFF;
            endcase
        end
    end

    assign op_a = op_cruise ? cruise_q : speed_q;

    add_sub u_add_sub (
        .a      (op_a),
        .sub    (op_sub_c),
        .result (op_result),
        .carry  (op_carry)
    );

    always_comb begin
        speed_n  = speed_q;
        cruise_n = cruise_q;
        if (op_en) begin
            if (op_cruise) begin
                if (floor_en && (!op_carry || (op_result < MIN_CRUISE))) begin
                    cruise_n = MIN_CRUISE;
                end else begin
                    cruise_n = op_result;
                end
            end else begin
                speed_n = op_result;
            end
        end
        if (cap) begin
            cruise_n = speed_q;
        end
        if (snap) begin
            speed_n = cruise_q;
        end
        if (clr) begin
            cruise_n = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_OFF;
            speed_q    <= 8'd0;
            cruise_q   <= 8'd0;
            op_valid_q <= 1'b0;
            op_sub_q   <= 1'b0;
        end else begin
            state_q    <= state_n;
            speed_q    <= speed_n;
            cruise_q   <= cruise_n;
            op_valid_q <= op_en;
            op_sub_q   <= op_en & op_sub_c;
        end
    end

    assign speed        = speed_q;
    assign cruise_speed = cruise_q;
    assign state        = state_q;
    assign op_valid     = op_valid_q;
    assign op_sub       = op_sub_q;

endmodule

// File: tb/tb_cruise_sched.sv
// Directed scoreboard bench for cruise_sched; expected wrap/saturate results follow
// CRUISE_SCHED_SAT_EN.
module tb_cruise_sched;

    logic       clk;
    logic       reset, on, off, set, brake, accel, decel;
    logic [7:0] speed, cruise_speed;
    logic [1:0] state;
    logic       op_valid, op_sub;

    // MIN_CRUISE of 48 lets the decel floor seed an odd target so speed can reach 253.
    cruise_sched #(.MIN_CRUISE(8'd48)) dut (
        .clk          (clk),
        .reset        (reset),
        .on           (on),
        .off          (off),
        .set          (set),
        .brake        (brake),
        .accel        (accel),
        .decel        (decel),
        .speed        (speed),
        .cruise_speed (cruise_speed),
        .state        (state),
        .op_valid     (op_valid),
        .op_sub       (op_sub)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] R_NONE = 7'b0000000;
    localparam logic [6:0] R_RST  = 7'b1000000;
    localparam logic [6:0] R_OFF  = 7'b0100000;
    localparam logic [6:0] R_ON   = 7'b0010000;
    localparam logic [6:0] R_SET  = 7'b0001000;
    localparam logic [6:0] R_BRK  = 7'b0000100;
    localparam logic [6:0] R_ACC  = 7'b0000010;
    localparam logic [6:0] R_DEC  = 7'b0000001;

`ifdef CRUISE_SCHED_SAT_EN
    localparam logic [7:0] EXP_253_UP  = 8'd255;
    localparam logic [7:0] EXP_3_DOWN  = 8'd0;
    localparam logic [7:0] EXP_0_DOWN  = 8'd0;
`else
    localparam logic [7:0] EXP_253_UP  = 8'd2;
    localparam logic [7:0] EXP_3_DOWN  = 8'd254;
    localparam logic [7:0] EXP_0_DOWN  = 8'd251;
`endif

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic [7:0] spd;
        logic [7:0] cr;
        logic       ov;
        logic       os;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_total = 0;

    task automatic chk(input string tag, input string field,
                       input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [6:0] req,
                        input logic [1:0] st, input logic [7:0] spd, input logic [7:0] cr,
                        input logic ov, input logic os);
        exp_t e;
        e.tag = tag; e.st = st; e.spd = spd; e.cr = cr; e.ov = ov; e.os = os;
        sb.push_back(e);
        {reset, off, on, set, brake, accel, decel} = req;
        @(posedge clk);
        @(negedge clk);
        {reset, off, on, set, brake, accel, decel} = R_NONE;
        if (sb.size() == 0) begin
            n_total++;
            n_fail++;
            $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk(e.tag, "state", {6'd0, state}, {6'd0, e.st});
            chk(e.tag, "speed", speed, e.spd);
            chk(e.tag, "cruise_speed", cruise_speed, e.cr);
            chk(e.tag, "op_valid", {7'd0, op_valid}, {7'd0, e.ov});
            chk(e.tag, "op_sub", {7'd0, op_sub}, {7'd0, e.os});
        end
    endtask

    // Ends in OFF with speed 253 and cruise_speed cleared.
    task automatic reach_253();
        step("r253_rst", R_RST, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        step("r253_arm", R_ON, 2'd1, 8'd0, 8'd0, 1'b0, 1'b0);
        step("set_below_min", R_SET, 2'd1, 8'd0, 8'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++)
            step("accel_armed", R_ACC, 2'd1, 8'(5 * i), 8'd0, 1'b1, 1'b0);
        step("r253_set", R_SET, 2'd2, 8'd50, 8'd50, 1'b0, 1'b0);
        step("decel_floor", R_DEC, 2'd2, 8'd50, 8'd48, 1'b1, 1'b1);
        step("decel_at_floor", R_DEC, 2'd2, 8'd50, 8'd48, 1'b1, 1'b1);
        for (int i = 1; i <= 41; i++)
            step("tgt_climb", R_ACC, 2'd2, 8'd50, 8'(48 + 5 * i), 1'b1, 1'b0);
        for (int i = 1; i <= 40; i++)
            step("regulate_up", R_NONE, 2'd2, 8'(50 + 5 * i), 8'd253, 1'b1, 1'b0);
        step("regulate_snap", R_NONE, 2'd2, 8'd253, 8'd253, 1'b0, 1'b0);
        step("regulate_hold", R_NONE, 2'd2, 8'd253, 8'd253, 1'b0, 1'b0);
        step("r253_off", R_OFF, 2'd0, 8'd253, 8'd0, 1'b0, 1'b0);
    endtask

    initial begin
        {reset, off, on, set, brake, accel, decel} = R_NONE;
        @(negedge clk);

        step("reset", R_RST, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++)
            step("accel_off", R_ACC, 2'd0, 8'(5 * i), 8'd0, 1'b1, 1'b0);
        step("arm", R_ON, 2'd1, 8'd50, 8'd0, 1'b0, 1'b0);
        step("set50", R_SET, 2'd2, 8'd50, 8'd50, 1'b0, 1'b0);
        step("tgt_up1", R_ACC, 2'd2, 8'd50, 8'd55, 1'b1, 1'b0);
        step("tgt_up2", R_ACC, 2'd2, 8'd50, 8'd60, 1'b1, 1'b0);
        step("reg55", R_NONE, 2'd2, 8'd55, 8'd60, 1'b1, 1'b0);
        step("reg60", R_NONE, 2'd2, 8'd60, 8'd60, 1'b1, 1'b0);
        step("reg_idle", R_NONE, 2'd2, 8'd60, 8'd60, 1'b0, 1'b0);
        step("on_ignored", R_ON, 2'd2, 8'd60, 8'd60, 1'b0, 1'b0);
        step("brake_hold", R_BRK, 2'd3, 8'd55, 8'd60, 1'b1, 1'b1);
        step("resume", R_ACC, 2'd2, 8'd55, 8'd60, 1'b0, 1'b0);
        step("regain", R_NONE, 2'd2, 8'd60, 8'd60, 1'b1, 1'b0);
        step("off_prio", R_OFF | R_BRK | R_SET, 2'd0, 8'd60, 8'd0, 1'b0, 1'b0);
        step("rearm", R_ON, 2'd1, 8'd60, 8'd0, 1'b0, 1'b0);
        step("reset60", R_SET, 2'd2, 8'd60, 8'd60, 1'b0, 1'b0);
        step("reset_mid", R_RST | R_ACC, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        step("brake_over_accel", R_BRK | R_ACC, 2'd0, EXP_0_DOWN, 8'd0, 1'b1, 1'b1);

        reach_253();
        step("edge_253_up", R_ACC, 2'd0, EXP_253_UP, 8'd0, 1'b1, 1'b0);

        reach_253();
        for (int i = 1; i <= 50; i++)
            step("decel_off", R_DEC, 2'd0, 8'(253 - 5 * i), 8'd0, 1'b1, 1'b1);
        step("edge_3_down", R_DEC, 2'd0, EXP_3_DOWN, 8'd0, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
